mem_arbiter: RTL and testbench

- Two-requester arbiter that shares one single-port synchronous RAM.
- Requester 0 is the processor core; requester 1 is the boot loader / debug DMA port.
- Each access is latched at grant, driven to the RAM for one cycle, and completed with a done pulse carrying read data.
- The RAM side uses the same strobe/mask protocol as the core: rstrb for reads, 4-bit byte wmask for writes, read data valid one cycle after rstrb.

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous RAM (IDLE/ACC/RSP).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed m0 > m1.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_wmask_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_done_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_wmask_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_done_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rstrb_o,
  output logic [3:0]        mem_wmask_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                owner_r, owner_nxt_s;
  logic                winner_s, any_req_s, sample_s;
  logic                we_r, we_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [3:0]          wmask_r, wmask_nxt_s;
  logic [DATA_W-1:0]   wdata_r, wdata_nxt_s;
  logic                gnt0_r, gnt1_r, done0_r, done1_r, rstrb_r;
  logic [3:0]          mem_wmask_r;

  assign any_req_s = m0_req_i | m1_req_i;
  // Requests only count at arbitration points, so a req held through ACC is not re-served.
  assign sample_s  = any_req_s && ((state_r == IDLE) || (state_r == RSP));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_r;

  // Round-robin pick: on a tie the port not granted last wins.
  always_comb begin
    if (m0_req_i && m1_req_i) begin
      winner_s = ~last_owner_r;
    end else if (m1_req_i) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Remember the most recent grant; resets to 1 so m0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_owner_r <= 1'b1;
    end else if (sample_s) begin
      last_owner_r <= winner_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`else
  // Fixed-priority pick: m0 always beats m1.
  always_comb begin
    if (m0_req_i) begin
      winner_s = 1'b0;
    end else if (m1_req_i) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end
`endif

  // Next-state logic and payload latch selection.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    we_nxt_s    = we_r;
    addr_nxt_s  = addr_r;
    wmask_nxt_s = wmask_r;
    wdata_nxt_s = wdata_r;
    case (state_r)
      IDLE:    state_nxt_s = sample_s ? ACC : IDLE;
      ACC:     state_nxt_s = RSP;
      RSP:     state_nxt_s = sample_s ? ACC : IDLE;
      default: state_nxt_s = IDLE;
    endcase
    if (sample_s) begin
      owner_nxt_s = winner_s;
      if (winner_s) begin
        we_nxt_s    = m1_we_i;
        addr_nxt_s  = m1_addr_i;
        wmask_nxt_s = m1_wmask_i;
        wdata_nxt_s = m1_wdata_i;
      end else begin
        we_nxt_s    = m0_we_i;
        addr_nxt_s  = m0_addr_i;
        wmask_nxt_s = m0_wmask_i;
        wdata_nxt_s = m0_wdata_i;
      end
    end else begin
      owner_nxt_s = owner_r;
    end
  end

  // State, latched access and registered control outputs (decoded from next state).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wmask_r     <= 4'b0000;
      wdata_r     <= {DATA_W{1'b0}};
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      done0_r     <= 1'b0;
      done1_r     <= 1'b0;
      rstrb_r     <= 1'b0;
      mem_wmask_r <= 4'b0000;
    end else begin
      state_r     <= state_nxt_s;
      owner_r     <= owner_nxt_s;
      we_r        <= we_nxt_s;
      addr_r      <= addr_nxt_s;
      wmask_r     <= wmask_nxt_s;
      wdata_r     <= wdata_nxt_s;
      gnt0_r      <= (state_nxt_s == ACC) && !owner_nxt_s;
      gnt1_r      <= (state_nxt_s == ACC) && owner_nxt_s;
      done0_r     <= (state_nxt_s == RSP) && !owner_nxt_s;
      done1_r     <= (state_nxt_s == RSP) && owner_nxt_s;
      rstrb_r     <= (state_nxt_s == ACC) && !we_nxt_s;
      mem_wmask_r <= ((state_nxt_s == ACC) && we_nxt_s) ? wmask_nxt_s : 4'b0000;
    end
  end

  assign m0_gnt_o    = gnt0_r;
  assign m1_gnt_o    = gnt1_r;
  assign m0_done_o   = done0_r;
  assign m1_done_o   = done1_r;
  assign mem_rstrb_o = rstrb_r;
  assign mem_wmask_o = mem_wmask_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  // RAM data arrives in RSP; steer it only to the port being completed.
  assign m0_rdata_o  = done0_r ? mem_rdata_i : {DATA_W{1'b0}};
  assign m1_rdata_o  = done1_r ? mem_rdata_i : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_gnt, m0_done, m1_gnt, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;

  logic [31:0] ram [0:63];
  logic [31:0] ram_rdata;
  logic        pl_we;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wmask_i(m0_wmask),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_done_o(m0_done), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wmask_i(m1_wmask),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_done_o(m1_done), .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_rstrb_o(mem_rstrb), .mem_wmask_o(mem_wmask),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data one cycle after rstrb, byte-masked writes.
  always @(posedge clk) begin
    if (pl_we) begin
      ram[pl_idx] <= pl_data;
    end else begin
      if (mem_rstrb) ram_rdata <= ram[mem_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end
  assign mem_rdata = ram_rdata;

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pl_idx = idx; pl_data = data; pl_we = 1'b1;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; m0_req = 1'b1; m0_addr = 32'h0000_0010;
    @(negedge clk); @(negedge clk);
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_m0_gnt got=%b exp=0", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_m1_gnt got=%b exp=0", m1_gnt); end
    checks++; if ({m0_done, m1_done} !== 2'b00) begin errors++; $display("FAIL reset_done got=%b exp=00", {m0_done, m1_done}); end
    checks++; if (mem_rstrb !== 1'b0) begin errors++; $display("FAIL reset_rstrb got=%b exp=0", mem_rstrb); end
    checks++; if (mem_wmask !== 4'b0000) begin errors++; $display("FAIL reset_wmask got=%b exp=0000", mem_wmask); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    rst = 1'b0; m0_req = 1'b0; m0_addr = 32'h0;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_idle_gnt got=%b exp=0", m0_gnt); end
  endtask

  task automatic test_m0_read;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%b exp=1", m0_gnt); end
    checks++; if (mem_rstrb !== 1'b1) begin errors++; $display("FAIL rd_rstrb got=%b exp=1", mem_rstrb); end
    checks++; if (mem_addr !== 32'h0000_0010) begin errors++; $display("FAIL rd_addr got=%h exp=00000010", mem_addr); end
    checks++; if ({m1_gnt, m1_done} !== 2'b00) begin errors++; $display("FAIL rd_m1_acc got=%b exp=00", {m1_gnt, m1_done}); end
    m0_req = 1'b0;
    @(negedge clk);
    checks++; if (m0_done !== 1'b1) begin errors++; $display("FAIL rd_done got=%b exp=1", m0_done); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", m0_rdata); end
    checks++; if ({m0_gnt, mem_rstrb, m1_done} !== 3'b000) begin errors++; $display("FAIL rd_rsp_ctl got=%b exp=000", {m0_gnt, mem_rstrb, m1_done}); end
    @(negedge clk);
    checks++; if ({m0_done, m0_gnt} !== 2'b00) begin errors++; $display("FAIL rd_idle got=%b exp=00", {m0_done, m0_gnt}); end
  endtask

  task automatic test_m1_write;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0020; m1_wmask = 4'b0100; m1_wdata = 32'h00AB_0000;
    @(negedge clk);
    checks++; if ({m1_gnt, m0_gnt} !== 2'b10) begin errors++; $display("FAIL wr_gnt got=%b exp=10", {m1_gnt, m0_gnt}); end
    checks++; if (mem_wmask !== 4'b0100) begin errors++; $display("FAIL wr_wmask got=%b exp=0100", mem_wmask); end
    checks++; if (mem_rstrb !== 1'b0) begin errors++; $display("FAIL wr_rstrb got=%b exp=0", mem_rstrb); end
    checks++; if (mem_wdata !== 32'h00AB_0000) begin errors++; $display("FAIL wr_wdata got=%h exp=00ab0000", mem_wdata); end
    m1_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_wmask !== 4'b0000) begin errors++; $display("FAIL wr_wmask_rsp got=%b exp=0000", mem_wmask); end
    checks++; if ({m1_done, m0_done} !== 2'b10) begin errors++; $display("FAIL wr_done got=%b exp=10", {m1_done, m0_done}); end
    @(negedge clk);
    checks++; if (m1_done !== 1'b0) begin errors++; $display("FAIL wr_done_once got=%b exp=0", m1_done); end
    checks++; if (ram[8] !== 32'h11AB_3344) begin errors++; $display("FAIL wr_ram got=%h exp=11ab3344", ram[8]); end
    m1_we = 1'b0; m1_wmask = 4'b0000; m1_wdata = 32'h0;
  endtask

  task automatic test_zero_wmask;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0020; m0_wmask = 4'b0000; m0_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if ({m0_gnt, mem_rstrb, mem_wmask} !== 6'b100000) begin errors++; $display("FAIL zw_acc got=%b exp=100000", {m0_gnt, mem_rstrb, mem_wmask}); end
    m0_req = 1'b0;
    @(negedge clk);
    checks++; if (m0_done !== 1'b1) begin errors++; $display("FAIL zw_done got=%b exp=1", m0_done); end
    @(negedge clk);
    checks++; if (ram[8] !== 32'h11AB_3344) begin errors++; $display("FAIL zw_ram got=%h exp=11ab3344", ram[8]); end
    m0_we = 1'b0; m0_wdata = 32'h0;
  endtask

  task automatic test_simultaneous;
    m0_req = 1'b1; m0_addr = 32'h0000_0010;
    m1_req = 1'b1; m1_addr = 32'h0000_0020;
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL sim_gnt_a got=%b exp=10", {m0_gnt, m1_gnt}); end
    m0_req = 1'b0;
    @(negedge clk);
    checks++; if ({m0_done, m1_done} !== 2'b10) begin errors++; $display("FAIL sim_done_a got=%b exp=10", {m0_done, m1_done}); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sim_data_a got=%h exp=deadbeef", m0_rdata); end
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt, m0_done, m1_done} !== 4'b0100) begin errors++; $display("FAIL sim_gnt_b got=%b exp=0100", {m0_gnt, m1_gnt, m0_done, m1_done}); end
    checks++; if (mem_addr !== 32'h0000_0020) begin errors++; $display("FAIL sim_addr_b got=%h exp=00000020", mem_addr); end
    m1_req = 1'b0;
    @(negedge clk);
    checks++; if ({m0_done, m1_done} !== 2'b01) begin errors++; $display("FAIL sim_done_b got=%b exp=01", {m0_done, m1_done}); end
    checks++; if (m1_rdata !== 32'h11AB_3344) begin errors++; $display("FAIL sim_data_b got=%h exp=11ab3344", m1_rdata); end
    @(negedge clk);
  endtask

  task automatic test_arbitration;
    logic exp1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h0000_0010;
    m1_req = 1'b1; m1_addr = 32'h0000_0020;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp1 = (i % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      @(negedge clk);
      checks++; if ({m0_gnt, m1_gnt} !== {~exp1, exp1}) begin errors++; $display("FAIL arb_gnt[%0d] got=%b exp=%b", i, {m0_gnt, m1_gnt}, {~exp1, exp1}); end
      if (i == 5) begin m0_req = 1'b0; m1_req = 1'b0; end
      @(negedge clk);
      checks++; if ({m0_done, m1_done} !== {~exp1, exp1}) begin errors++; $display("FAIL arb_done[%0d] got=%b exp=%b", i, {m0_done, m1_done}, {~exp1, exp1}); end
    end
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL arb_idle got=%b exp=00", {m0_gnt, m1_gnt}); end
  endtask

  task automatic test_reset_in_acc;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL racc_gnt got=%b exp=1", m0_gnt); end
    rst = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    checks++; if ({m0_done, mem_rstrb, m0_gnt} !== 3'b000) begin errors++; $display("FAIL racc_abort got=%b exp=000", {m0_done, mem_rstrb, m0_gnt}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m0_done !== 1'b0) begin errors++; $display("FAIL racc_nodone got=%b exp=0", m0_done); end
    m0_req = 1'b1;
    @(negedge clk);
    checks++; if ({m0_gnt, mem_rstrb} !== 2'b11) begin errors++; $display("FAIL racc_regnt got=%b exp=11", {m0_gnt, mem_rstrb}); end
    m0_req = 1'b0;
    @(negedge clk);
    checks++; if ({m0_done, m0_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL racc_redone got=%b/%h exp=1/deadbeef", m0_done, m0_rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [0:2];
    exp_d[0] = 32'h0123_4567; exp_d[1] = 32'h89AB_CDEF; exp_d[2] = 32'h5555_AAAA;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({m0_gnt, mem_rstrb} !== 2'b11) begin errors++; $display("FAIL b2b_acc[%0d] got=%b exp=11", i, {m0_gnt, mem_rstrb}); end
      checks++; if (mem_addr !== 32'(4 * i)) begin errors++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, mem_addr, 32'(4 * i)); end
      if (i == 2) m0_req = 1'b0;
      else m0_addr = 32'(4 * (i + 1));
      @(negedge clk);
      checks++; if ({m0_done, mem_rstrb} !== 2'b10) begin errors++; $display("FAIL b2b_rsp[%0d] got=%b exp=10", i, {m0_done, mem_rstrb}); end
      checks++; if (m0_rdata !== exp_d[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, m0_rdata, exp_d[i]); end
    end
    @(negedge clk);
    checks++; if ({m0_done, mem_rstrb} !== 2'b00) begin errors++; $display("FAIL b2b_idle got=%b exp=00", {m0_done, mem_rstrb}); end
  endtask

  initial begin
    rst = 1'b1; pl_we = 1'b0; pl_idx = 6'd0; pl_data = 32'h0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wmask = 4'b0000; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wmask = 4'b0000; m1_wdata = 32'h0;
    preload(6'd0, 32'h0123_4567);
    preload(6'd1, 32'h89AB_CDEF);
    preload(6'd2, 32'h5555_AAAA);
    preload(6'd4, 32'hDEAD_BEEF);
    preload(6'd8, 32'h1122_3344);
    test_reset();
    test_m0_read();
    test_m1_write();
    test_zero_wmask();
    test_simultaneous();
    test_arbitration();
    test_reset_in_acc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
